uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive buffer directly downstream of the UART receiver. Captures each received
//   byte (in_data qualified by a rising edge of in_rdy) into a DEPTH-entry FIFO.
//   Presents bytes to the consumer over a valid/ready read port.
//   Reports fill level, an almost-full warning and a sticky overflow flag.
// PARAMETERS
//   DEPTH     16   FIFO entries; power of 2, >= 2
//   AFULL_LVL 12   almost_full asserts when count >= AFULL_LVL; 1..DEPTH
//   CW        $clog2(DEPTH+1)   count width (localparam, not overridable)
// PORTS
//   clk          in   1    system clock (same clock as the UART receiver)
//   rst_n        in   1    asynchronous active-low reset
//   in_data      in   8    received byte from UART receiver
//   in_rdy       in   1    byte-ready level/pulse from UART receiver
//   rd_data      out  8    head-of-FIFO byte; valid while rd_valid=1
//   rd_valid     out  1    FIFO non-empty
//   rd_ready     in   1    consumer accepts rd_data this cycle
//   count        out  CW   current number of stored bytes, 0..DEPTH
//   full         out  1    count == DEPTH
//   almost_full  out  1    count >= AFULL_LVL
//   overflow     out  1    sticky: a byte was dropped because FIFO was full
//   ovf_clr      in   1    clears overflow
// BEHAVIOUR
//   Reset (async, rst_n=0): pointers=0, count=0, rd_valid=0, full=0,
//     almost_full=0, overflow=0, in_rdy_d=0, storage contents don't-care,
//     rd_data=0. Reset mid-operation discards all stored bytes.
//   Write strobe: wr_stb = in_rdy & ~in_rdy_d (in_rdy_d = in_rdy registered).
//     A level held high for many cycles writes exactly once.
//     in_data is sampled in the wr_stb cycle.
//   Read transfer: rd_xfer = rd_valid & rd_ready; rd_ready while empty is ignored.
//   Accept rule: write accepted iff wr_stb & (~full | rd_xfer).
//     Full + simultaneous read + write: both occur, count unchanged.
//   Count update, registered on the clock edge:
//     +1 on accepted write only; -1 on read only; unchanged on both or neither.
//   Pointers: wr_ptr/rd_ptr are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//   Flags: full, almost_full and rd_valid (= count != 0) are all derived from
//     registered count; no combinational path from in_* or rd_ready.
//   Head output: rd_data = mem[rd_ptr], combinational from registered state.
//     rd_data = 0 when empty.
//   Latency: byte written at edge N is visible (rd_valid=1, rd_data) after edge N.
//     No empty bypass: same-cycle write+read on an empty FIFO reads nothing.
//   Ordering: strict FIFO; rd_data is stable while rd_valid=1 and rd_ready=0.
//   Overflow: wr_stb & full & ~rd_xfer drops the byte.
//     Storage and count are unchanged; overflow <= 1.
//     ovf_clr clears overflow. A new drop in the same cycle as ovf_clr wins
//     (overflow stays 1).
// TESTING
//   1 Reset, then write 0xA5 via a 1-cycle in_rdy pulse
//     -> next cycle rd_valid=1, rd_data=0xA5, count=1.
//     rd_ready=1 for 1 cycle -> rd_valid=0, count=0.
//   2 Hold in_rdy high 10 cycles with in_data=0x3C -> exactly one entry, count=1.
//   3 Write 0x00..0x0F (DEPTH=16) -> full=1 and almost_full=1 (from count=12).
//     Write 0x55 -> dropped, overflow=1. Drain -> reads 0x00..0x0F in order.
//   4 Full FIFO, wr_stb and rd_xfer in the same cycle with 0x77
//     -> count stays 16, overflow stays 0, 0x77 is read last.
//   5 Fill, drain, refill 40 bytes with interleaved reads (pointer wrap)
//     -> output sequence equals input sequence; count always matches scoreboard.
//   6 Assert rst_n=0 with count=7 mid-transfer -> all outputs zero immediately.
//     ovf_clr pulsed in the same cycle as a drop -> overflow remains 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: edge-detected capture of in_data,
// valid/ready head port, fill level, almost-full warning and a sticky overflow flag.
module uart_rx_fifo #(
    parameter  int DEPTH     = 16,
    parameter  int AFULL_LVL = 12,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_rdy,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          almost_full,
    output logic          overflow,
    input  logic          ovf_clr
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_rdy_prev_q, in_rdy_prev_d;
    logic          overflow_q, overflow_d;
    logic          is_full, is_empty, wr_stb, rd_xfer, wr_en, drop;

    always_comb begin
        is_full       = (count_q == CW'(DEPTH));
        is_empty      = (count_q == '0);
        wr_stb        = in_rdy & ~in_rdy_prev_q;
        rd_xfer       = ~is_empty & rd_ready;
        // A full FIFO still takes a byte when the head leaves in the same cycle
        wr_en         = wr_stb & (~is_full | rd_xfer);
        drop          = wr_stb & is_full & ~rd_xfer;
        in_rdy_prev_d = in_rdy;
        wr_ptr_d      = wr_en   ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = rd_xfer ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d       = count_q;
        if (wr_en && !rd_xfer) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && rd_xfer) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            in_rdy_prev_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            in_rdy_prev_q <= in_rdy_prev_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage is data only; its contents are meaningless until count says otherwise
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign count       = count_q;
    assign full        = is_full;
    assign almost_full = (count_q >= CW'(AFULL_LVL));
    assign rd_valid    = ~is_empty;
    assign overflow    = overflow_q;
    assign rd_data     = is_empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_rdy = 1'b0;
    logic          rd_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          full, almost_full, overflow;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_rdy(in_rdy),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .count(count), .full(full), .almost_full(almost_full),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    byte unsigned q[$];
    bit           m_prev = 1'b0;
    bit           m_ovf  = 1'b0;
    logic [7:0]   last_rd = 8'h00;
    int           passed = 0;
    int           total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(n != 0));
        chk({tag, ".rd_data"}, 32'(rd_data), (n != 0) ? 32'(q[0]) : 32'h0);
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AFULL));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Apply the model for one clock using the inputs as currently driven, then advance
    task automatic tick();
        bit stb, xfer, was_full;
        stb      = in_rdy && !m_prev;
        xfer     = rd_ready && (q.size() != 0);
        was_full = (q.size() == DEPTH);
        if (xfer) begin
            chk("read_order", 32'(rd_data), 32'(q[0]));
            last_rd = q.pop_front();
        end
        if (stb && (!was_full || xfer)) q.push_back(in_data);
        if (stb && was_full && !xfer) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_prev = in_rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_write(input logic [7:0] v);
        in_data = v;
        in_rdy  = 1'b1;
        tick();
        in_rdy  = 1'b0;
        tick();
        check_all("wr");
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            tick();
            check_all("drain");
        end
        rd_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        tick();

        // 1: single pulse write and read
        in_data = 8'hA5;
        in_rdy  = 1'b1;
        tick();
        in_rdy  = 1'b0;
        chk("t1.rd_data", 32'(rd_data), 32'hA5);
        chk("t1.count", 32'(count), 32'd1);
        check_all("t1");
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("t1.empty", 32'(rd_valid), 32'd0);
        check_all("t1b");

        // 2: held level writes exactly once
        in_data = 8'h3C;
        in_rdy  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all("t2");
        end
        in_rdy = 1'b0;
        tick();
        chk("t2.count", 32'(count), 32'd1);
        drain();

        // 3: fill, overflow drop, ordered drain
        for (int i = 0; i < DEPTH; i++) pulse_write(8'(i));
        chk("t3.full", 32'(full), 32'd1);
        pulse_write(8'h55);
        chk("t3.overflow", 32'(overflow), 32'd1);
        drain();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_all("t3.clr");

        // 4: full with simultaneous write and read
        for (int i = 0; i < DEPTH; i++) pulse_write(8'($urandom_range(0, 255)));
        in_data  = 8'h77;
        in_rdy   = 1'b1;
        rd_ready = 1'b1;
        tick();
        in_rdy   = 1'b0;
        rd_ready = 1'b0;
        chk("t4.count", 32'(count), 32'd16);
        chk("t4.overflow", 32'(overflow), 32'd0);
        check_all("t4");
        drain();
        chk("t4.last", 32'(last_rd), 32'h77);

        // 5: random traffic with pointer wrap
        for (int i = 0; i < 400; i++) begin
            in_data  = 8'($urandom_range(0, 255));
            in_rdy   = ($urandom_range(0, 2) != 0);
            rd_ready = ($urandom_range(0, 2) == 0);
            ovf_clr  = ($urandom_range(0, 15) == 0);
            tick();
            check_all("t5");
        end
        in_rdy = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
        tick();
        drain();

        // 6: asynchronous reset mid-transfer with count=7
        for (int i = 0; i < 7; i++) pulse_write(8'($urandom_range(0, 255)));
        chk("t6.count7", 32'(count), 32'd7);
        in_data  = 8'h99;
        in_rdy   = 1'b1;
        rd_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6.count", 32'(count), 32'd0);
        chk("t6.rd_valid", 32'(rd_valid), 32'd0);
        chk("t6.rd_data", 32'(rd_data), 32'd0);
        chk("t6.full", 32'(full), 32'd0);
        chk("t6.almost_full", 32'(almost_full), 32'd0);
        chk("t6.overflow", 32'(overflow), 32'd0);
        in_rdy = 1'b0; rd_ready = 1'b0;
        q.delete();
        m_prev = 1'b0;
        m_ovf  = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_all("t6.after");

        // 6b: drop in the same cycle as ovf_clr keeps overflow set
        for (int i = 0; i < DEPTH; i++) pulse_write(8'(i + 8'h40));
        pulse_write(8'hE1);
        chk("t6.ovf_set", 32'(overflow), 32'd1);
        in_data = 8'hE2;
        in_rdy  = 1'b1;
        ovf_clr = 1'b1;
        tick();
        in_rdy  = 1'b0;
        ovf_clr = 1'b0;
        chk("t6.ovf_clr_drop", 32'(overflow), 32'd1);
        check_all("t6.clr_drop");
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t6.ovf_cleared", 32'(overflow), 32'd0);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
